// File: rtl/uart_word_rx_if.sv
// Serial line in, assembled word and status pulses out, for the UART word receiver.
interface uart_word_rx_if;
  logic        rx;
  logic [31:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic        busy;

  modport master (
    input  rx,
    output data_out,
    output data_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs four bytes (MSB first) into a 32-bit word.
// Zero, stale or malformed words are rejected because the consumer divides by data_out.
module uart_word_rx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned GAP_BITS   = 20,
  parameter logic [31:0] RESET_WORD = 32'd2000
) (
  input logic            clk,
  input logic            reset,
  uart_word_rx_if.master bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned GAP_CYCLES   = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned GapW         = $clog2(GAP_CYCLES + 1);

  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);
  localparam logic [GapW-1:0] GapLast  = GapW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [31:0]     asm_q, asm_d;
  logic            word_pend_q, word_pend_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [31:0]     data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            byte_done;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    word_pend_d  = 1'b0;
    gap_d        = gap_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    byte_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        // Sampled mid-stop-bit so a back-to-back start edge is not missed.
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d   = StIdle;
            byte_done = 1'b1;
          end else begin
            state_d     = StWaitIdle;
            frame_err_d = 1'b1;
            byte_idx_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitIdle: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (byte_done) begin
      unique case (byte_idx_q)
        2'd0: asm_d[31:24] = shift_q;
        2'd1: asm_d[23:16] = shift_q;
        2'd2: asm_d[15:8]  = shift_q;
        2'd3: asm_d[7:0]   = shift_q;
      endcase
      byte_idx_d  = byte_idx_q + 1'b1;
      word_pend_d = (byte_idx_q == 2'd3);
    end

    if (word_pend_q) begin
      if (asm_q != '0) begin
        data_out_d   = asm_q;
        data_valid_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
    end

    // Timeout is tested before start detect so an expiring word yields to a fresh byte 0.
    if ((state_q == StIdle) && (byte_idx_q != '0)) begin
      if (gap_q == GapLast) begin
        gap_d       = '0;
        byte_idx_d  = '0;
        frame_err_d = 1'b1;
      end else if (!rx_s_q) begin
        gap_d = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end else begin
      gap_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      word_pend_q  <= 1'b0;
      gap_q        <= '0;
      data_out_q   <= RESET_WORD;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= bus.rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      word_pend_q  <= word_pend_d;
      gap_q        <= gap_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != StIdle) || (byte_idx_q != '0);

endmodule

// File: tb/tb_uart_word_rx.sv
// Randomised and directed bench for uart_word_rx against a byte-level word model.
module tb_uart_word_rx;

  localparam int unsigned ClkFreq   = 1_600_000;
  localparam int unsigned Baud      = 100_000;
  localparam int unsigned Cpb       = ClkFreq / Baud;
  localparam int unsigned GapBits   = 20;
  localparam logic [31:0] ResetWord = 32'd2000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_word_rx_if bus ();

  uart_word_rx #(
    .CLK_FREQ  (ClkFreq),
    .BAUD      (Baud),
    .GAP_BITS  (GapBits),
    .RESET_WORD(ResetWord)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed events: {1, word} for data_valid, {0, 0} for frame_err.
  logic [32:0] act_q[$];
  int          overlap_cnt = 0;

  always @(negedge clk) begin
    if (bus.data_valid && bus.frame_err) overlap_cnt++;
    if (bus.data_valid) act_q.push_back({1'b1, bus.data_out});
    if (bus.frame_err) act_q.push_back({1'b0, 32'd0});
  end

  // Reference model: a word is just the last four good bytes, MSB first.
  logic [32:0] exp_q[$];
  int          pend_n;
  logic [31:0] pend_w;
  logic [31:0] exp_data;
  int          act_rd = 0;

  task automatic model_reset();
    pend_n   = 0;
    pend_w   = '0;
    exp_data = ResetWord;
  endtask

  // Gaps used are either <= 4 or >= 24 bit-times, clear of the 20-bit timeout.
  task automatic model_gap(input int bits);
    if (bits >= 24 && pend_n > 0) begin
      exp_q.push_back({1'b0, 32'd0});
      pend_n = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_q.push_back({1'b0, 32'd0});
      pend_n = 0;
    end else begin
      pend_w = (pend_w << 8) | 32'(b);
      pend_n++;
      if (pend_n == 4) begin
        pend_n = 0;
        if (pend_w != 0) begin
          exp_q.push_back({1'b1, pend_w});
          exp_data = pend_w;
        end else begin
          exp_q.push_back({1'b0, 32'd0});
        end
      end
    end
  endtask

  task automatic idle_bits(input int bits);
    bus.rx = 1'b1;
    repeat (bits * Cpb) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit good, input int gap);
    model_gap(gap);
    idle_bits(gap);
    model_byte(b, good);
    bus.rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    bus.rx = good;
    repeat (Cpb) @(negedge clk);
    bus.rx = 1'b1;
    if (!good) idle_bits(1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send(w[8*k +: 8], 1'b1, 0);
  endtask

  task automatic check_scenario(input string tag);
    idle_bits(2);
    check_eq({tag, "_nev"}, 64'(act_q.size() - act_rd), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (act_rd + i < act_q.size()) check_eq({tag, "_ev"}, 64'(act_q[act_rd + i]), 64'(exp_q[i]));
    end
    act_rd = act_q.size();
    exp_q.delete();
    check_eq({tag, "_data"}, 64'(bus.data_out), 64'(exp_data));
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'(pend_n != 0));
  endtask

  initial begin
    int          gap;
    bit          good;
    logic [7:0]  b;

    bus.rx = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_data", 64'(bus.data_out), 64'(ResetWord));
    check_eq("rst_valid", 64'(bus.data_valid), 64'd0);
    check_eq("rst_ferr", 64'(bus.frame_err), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);

    // Reset in the middle of the third byte abandons the partial word silently.
    send(8'h11, 1'b1, 1);
    send(8'h22, 1'b1, 0);
    bus.rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.rx = 1'(i & 1);
      repeat (Cpb) @(negedge clk);
    end
    reset  = 1'b1;
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_scenario("midrst");

    send_word(32'd1000);
    check_scenario("good");

    send_word(32'd0);
    check_scenario("zero");

    send(8'h12, 1'b1, 0);
    send(8'h34, 1'b0, 0);
    send_word(32'h5678_9ABC);
    check_scenario("frame");

    send(8'hAA, 1'b1, 0);
    send(8'hBB, 1'b1, 0);
    send(8'h00, 1'b1, 25);
    send(8'h01, 1'b1, 0);
    send(8'h86, 1'b1, 0);
    send(8'hA0, 1'b1, 0);
    check_scenario("gap");

    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    idle_bits(1);
    check_scenario("glitch");
    send_word(32'd10);
    check_scenario("glitch_word");

    for (int w = 0; w < 25; w++) begin
      for (int k = 0; k < 4; k++) begin
        gap  = ($urandom_range(0, 29) == 0) ? int'($urandom_range(24, 28))
                                            : int'($urandom_range(0, 4));
        good = ($urandom_range(0, 24) != 0);
        b    = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        send(b, good, gap);
      end
      check_scenario("rand");
    end
    model_gap(26);
    idle_bits(26);
    check_scenario("rand_flush");

    check_eq("overlap", 64'(overlap_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
